// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_resp data-memory responder.
// Holds the FSM state enum, word/lane geometry constants and the
// latched-request payload struct used by dmem_resp and dmem_array.
package dmem_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic                 we;
      logic [WORD_W-1:0]    addr;
      logic [WORD_W-1:0]    wdata;
      logic [NUM_LANES-1:0] be;
   } req_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage for dmem_resp: synchronous byte-lane write and a
// registered read port. Contents are deliberately never reset.
// Ports:
//   clk      - clock
//   we_i     - write strobe (lanes selected by be_i)
//   re_i     - read strobe; loads rdata_o from the addressed word
//   idx_i    - word index
//   wdata_i  - write data
//   be_i     - byte-lane enables
//   rdata_o  - registered read data (holds until the next read)
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned AW          = 6
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic                 re_i,
   input  logic [AW-1:0]        idx_i,
   input  logic [WORD_W-1:0]    wdata_i,
   input  logic [NUM_LANES-1:0] be_i,
   output logic [WORD_W-1:0]    rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
   logic [WORD_W-1:0] rdata_q;

   // Byte-lane write and registered read
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < int'(NUM_LANES); b++) begin
            if (be_i[b]) begin
               mem_q[idx_i][BYTE_W*b +: BYTE_W] <= wdata_i[BYTE_W*b +: BYTE_W];
            end
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding data-memory responder with a fixed number of wait
// states between request acceptance and the response.
// Optional feature macro: DMEM_RESP_ERR_EN -- when defined, misaligned or
// out-of-range addresses are rejected (rsp_err=1, no write, rdata 0);
// otherwise low address bits are ignored and high bits wrap.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   req_valid/ready - request handshake (ready only in IDLE)
//   req_we/addr/wdata/be - request payload (byte address, lane enables)
//   rsp_valid/ready - response handshake
//   rsp_rdata       - read data, 0 for writes and rejected requests
//   rsp_err         - request was rejected
module dmem_resp
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [WORD_W-1:0]    req_addr,
   input  logic [WORD_W-1:0]    req_wdata,
   input  logic [NUM_LANES-1:0] req_be,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WORD_W-1:0]    rsp_rdata,
   output logic                 rsp_err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rd_ok_q, rd_ok_d;

   req_t              cur_c;
   logic              accept_c;
   logic              enter_resp_c;
   logic              err_c;
   logic              arr_we_c;
   logic              arr_re_c;
   logic [WORD_W-1:0] arr_rdata;

   // In IDLE the live request is used so a zero-wait access can hit the
   // array on the acceptance edge; otherwise the latched copy is used.
   always_comb begin
      cur_c = req_q;
      if (state_q == IDLE) begin
         cur_c.we    = req_we;
         cur_c.addr  = req_addr;
         cur_c.wdata = req_wdata;
         cur_c.be    = req_be;
      end
   end

   assign accept_c = req_valid && req_ready_q;

`ifdef DMEM_RESP_ERR_EN
   assign err_c = (cur_c.addr[1:0] != 2'b00) || (cur_c.addr[WORD_W-1:AW+2] != '0);
`else
   assign err_c = 1'b0;
   logic unused_addr_c;
   assign unused_addr_c = ^{cur_c.addr[WORD_W-1:AW+2], cur_c.addr[1:0]};
`endif

   // State and registered-output update
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_ok_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rd_ok_q     <= rd_ok_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      enter_resp_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               req_d = cur_c;
               if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d      = RESP;
                  enter_resp_c = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d      = RESP;
               enter_resp_c = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      rsp_err_d   = rsp_err_q;
      rd_ok_d     = rd_ok_q;
      if (enter_resp_c) begin
         rsp_err_d = err_c;
         rd_ok_d   = !cur_c.we && !err_c;
      end else if (state_d != RESP) begin
         rsp_err_d = 1'b0;
         rd_ok_d   = 1'b0;
      end
   end

   // Array is touched only on the edge entering RESP
   assign arr_we_c = enter_resp_c &&  cur_c.we && !err_c;
   assign arr_re_c = enter_resp_c && !cur_c.we && !err_c;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we_c),
      .re_i    (arr_re_c),
      .idx_i   (cur_c.addr[AW+1:2]),
      .wdata_i (cur_c.wdata),
      .be_i    (cur_c.be),
      .rdata_o (arr_rdata)
   );

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   // Read register is only meaningful for accepted, error-free reads
   assign rsp_rdata = arr_rdata & {WORD_W{rd_ok_q}};

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: a WAIT_CYCLES=2 instance driven from a
// vector table plus stall/reset sequences, and a WAIT_CYCLES=0 instance
// exercised back-to-back.
module tb_dmem_resp;

   logic        clk;
   logic        rst_n;

   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   logic        req_valid0, req_ready0, req_we0;
   logic [31:0] req_addr0, req_wdata0;
   logic [3:0]  req_be0;
   logic        rsp_valid0, rsp_ready0, rsp_err0;
   logic [31:0] rsp_rdata0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t tbl[$];

   dmem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   dmem_resp #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
      .clk       (clk),
      .reset     (rst_n),
      .req_valid (req_valid0),
      .req_ready (req_ready0),
      .req_we    (req_we0),
      .req_addr  (req_addr0),
      .req_wdata (req_wdata0),
      .req_be    (req_be0),
      .rsp_valid (rsp_valid0),
      .rsp_ready (rsp_ready0),
      .rsp_rdata (rsp_rdata0),
      .rsp_err   (rsp_err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      tbl.push_back(v);
   endtask

   // One full transaction on u_dut; starts and ends at posedge+1.
   task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat);
      int n;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      rsp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 20) begin
         total++; bad++;
         $display("FAIL accept_timeout: got req_ready=0 want 1");
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      @(posedge clk); #1;
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   logic [31:0] exp_10;

   initial begin
      req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
      req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0; rsp_ready0 = 1;
      rst_n = 1'b0;

      // Reset values
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err",   32'(rsp_err), 32'd0);
      #6 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      // Vector table
      add(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        0);
      add(0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0);
      add(1, 32'h10, 32'h11223344, 4'h5, 32'h0,        0);
      add(0, 32'h10, 32'h0,        4'h0, 32'hDE22BE44, 0);
      add(1, 32'h14, 32'h01234567, 4'hF, 32'h0,        0);
      add(1, 32'h14, 32'hCAFEF00D, 4'h0, 32'h0,        0);
      add(0, 32'h14, 32'h0,        4'h0, 32'h01234567, 0);
      add(1, 32'h18, 32'h00000000, 4'hF, 32'h0,        0);
      add(1, 32'h18, 32'hA5A5A5A5, 4'h8, 32'h0,        0);
      add(0, 32'h18, 32'h0,        4'h0, 32'hA5000000, 0);
`ifdef DMEM_RESP_ERR_EN
      add(1, 32'h12,  32'hFFFFFFFF, 4'hF, 32'h0,        1);
      add(1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1);
      add(0, 32'h10,  32'h0,        4'h0, 32'hDE22BE44, 0);
      add(0, 32'h13,  32'h0,        4'h0, 32'h0,        1);
      exp_10 = 32'hDE22BE44;
`else
      add(1, 32'h410, 32'h55667788, 4'hF, 32'h0,        0);
      add(0, 32'h10,  32'h0,        4'h0, 32'h55667788, 0);
      add(0, 32'h12,  32'h0,        4'h0, 32'h55667788, 0);
      exp_10 = 32'h55667788;
`endif
      for (int i = 0; i < tbl.size(); i++) begin
         xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat);
         check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
         check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      end

      // Response back-pressure: hold rsp_ready low for 5 cycles in RESP
      req_valid = 1; req_we = 0; req_addr = 32'h10; rsp_ready = 0;
      @(posedge clk); #1;
      req_valid = 0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("stall_latency", 32'(lat), 32'd3);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
         check($sformatf("stall%0d_rsp_rdata", i), rsp_rdata, exp_10);
         check($sformatf("stall%0d_req_ready", i), 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      check("stall_release_req_ready", 32'(req_ready), 32'd1);
      check("stall_release_rsp_valid", 32'(rsp_valid), 32'd0);

      // Reset during WAIT of a write to 0x20 aborts it
      xact(1, 32'h20, 32'h13579BDF, 4'hF, rd, er, lat);
      req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 0;
      check("abort_in_wait_req_ready", 32'(req_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("abort_req_ready", 32'(req_ready), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_rsp_rdata", rsp_rdata, 32'd0);
      check("abort_rsp_err",   32'(rsp_err), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_post_rst_req_ready", 32'(req_ready), 32'd1);
      xact(0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      check("abort_readback", rd, 32'h13579BDF);
      check("abort_readback_err", 32'(er), 32'd0);

      // Zero-wait instance, requests held back-to-back with rsp_ready tied 1
      check("zw_idle_req_ready", 32'(req_ready0), 32'd1);
      req_valid0 = 1; req_we0 = 1; req_addr0 = 32'h8; req_wdata0 = 32'h0BADF00D; req_be0 = 4'hF;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         check($sformatf("zw%0d_rsp_valid", k), 32'(rsp_valid0), 32'(k % 2));
         check($sformatf("zw%0d_req_ready", k), 32'(req_ready0), 32'(1 - (k % 2)));
         if (k == 1) begin
            check("zw1_write_rdata", rsp_rdata0, 32'h0);
            req_we0 = 0;
         end else if (k % 2 == 1) begin
            check($sformatf("zw%0d_read_rdata", k), rsp_rdata0, 32'h0BADF00D);
            check($sformatf("zw%0d_read_err", k), 32'(rsp_err0), 32'd0);
         end
      end
      req_valid0 = 0;
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
